// File: rtl/mux_mem_alu.sv
// mux_mem_alu: registered writeback mux choosing between the ALU result and a load word.
// Define MUX_MEM_ALU_LOAD_FMT_EN to compile in RISC-V load formatting and misalignment detection.
module mux_mem_alu #(
  parameter logic [31:0] RST_VAL = 32'h0000_0000
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [31:0] iv_Mem,
  input  logic [31:0] iv_Reg,
  input  logic        i_selector,
  input  logic [2:0]  iv_funct3,
  input  logic [1:0]  iv_addr_lo,
  input  logic        i_valid,
  input  logic        i_stall,
  output logic [31:0] ov_reg_Mem,
  output logic        o_valid,
  output logic        o_misaligned
);
  logic [31:0] mem_val, data_d, data_q;
  logic        valid_d, valid_q;
`ifdef MUX_MEM_ALU_LOAD_FMT_EN
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] fmt_val;
  logic        mis, mis_d, mis_q;
  always_comb begin
    byte_sel = iv_Mem[8*iv_addr_lo +: 8];
    half_sel = iv_addr_lo[1] ? iv_Mem[31:16] : iv_Mem[15:0];
    fmt_val  = (iv_funct3 == 3'b000) ? {{24{byte_sel[7]}}, byte_sel} :
               (iv_funct3 == 3'b100) ? {24'h0, byte_sel} :
               (iv_funct3 == 3'b001) ? {{16{half_sel[15]}}, half_sel} :
               (iv_funct3 == 3'b101) ? {16'h0, half_sel} : iv_Mem;
    // funct3[1:0] encodes access size: 00 byte, 01 half, otherwise word/reserved
    mis      = (iv_funct3[1:0] == 2'b00) ? 1'b0 :
               (iv_funct3[1:0] == 2'b01) ? iv_addr_lo[0] : (iv_addr_lo != 2'b00);
    mem_val  = mis ? 32'h0 : fmt_val;
    mis_d    = i_stall ? mis_q : (i_valid & i_selector & mis);
  end
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) mis_q <= 1'b0;
    else          mis_q <= mis_d;
  end
  assign o_misaligned = mis_q;
`else
  logic unused_fmt;
  assign unused_fmt   = ^{iv_funct3, iv_addr_lo};
  assign mem_val      = iv_Mem;
  assign o_misaligned = 1'b0;
`endif
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    if (!i_stall) begin
      valid_d = i_valid;
      data_d  = i_valid ? (i_selector ? mem_val : iv_Reg) : data_q;
    end
  end
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      data_q  <= RST_VAL;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end
  assign ov_reg_Mem = data_q;
  assign o_valid    = valid_q;
endmodule

// File: tb/tb_mux_mem_alu.sv
// tb_mux_mem_alu: directed and random checks of mux_mem_alu against an arithmetic reference model.
module tb_mux_mem_alu;
  localparam logic [31:0] RV = 32'hDEAD_BEEF;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] mem = '0, rg = '0;
  logic        sel = 1'b0, valid = 1'b0, stall = 1'b0;
  logic [2:0]  f3 = '0;
  logic [1:0]  addr = '0;
  logic [31:0] dout;
  logic        vout, mout;
  logic [31:0] e_d;
  logic        e_v, e_m;
  int total = 0, bad = 0;

  mux_mem_alu #(.RST_VAL(RV)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .iv_Mem(mem), .iv_Reg(rg), .i_selector(sel),
    .iv_funct3(f3), .iv_addr_lo(addr), .i_valid(valid), .i_stall(stall),
    .ov_reg_Mem(dout), .o_valid(vout), .o_misaligned(mout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic ref_load(output logic [31:0] v, output logic m);
    int unsigned b, h, sz;
    v = mem;
    m = 1'b0;
`ifdef MUX_MEM_ALU_LOAD_FMT_EN
    sz = (f3 % 4 == 0) ? 1 : (f3 % 4 == 1) ? 2 : 4;
    b  = (mem >> (8 * addr)) & 32'hFF;
    h  = (mem >> (16 * (addr / 2))) & 32'hFFFF;
    if (sz == 1) v = (f3 >= 4) ? b : b - ((b & 32'h80) << 1);
    else if (sz == 2) v = (f3 >= 4) ? h : h - ((h & 32'h8000) << 1);
    m = (addr % sz) != 0;
    if (m) v = 32'h0;
`endif
  endtask

  task automatic step(input string tag);
    logic [31:0] lv;
    logic        lm;
    ref_load(lv, lm);
    @(posedge clk);
    if (!rst_n) begin
      e_d = RV; e_v = 1'b0; e_m = 1'b0;
    end else if (!stall) begin
      e_v = valid;
      e_m = valid && sel && lm;
      if (valid) e_d = sel ? lv : rg;
    end
    #1;
    chk({tag, ".data"}, dout, e_d);
    chk({tag, ".valid"}, {31'h0, vout}, {31'h0, e_v});
    chk({tag, ".mis"}, {31'h0, mout}, {31'h0, e_m});
  endtask

  initial begin
    rst_n = 1'b0; stall = 1'b1; valid = 1'b1; sel = 1'b1; mem = 32'h1234_5678;
    step("reset");
    chk("reset_const", dout, RV);
    rst_n = 1'b1; stall = 1'b0;
    mem = 32'h1; rg = 32'h2; f3 = 3'b010; addr = 2'd0;
    for (int i = 0; i < 4; i++) begin
      sel = ~sel;
      step("toggle");
      chk("toggle_const", dout, sel ? 32'h1 : 32'h2);
    end
    sel = 1'b1; mem = 32'h80FF_7F01;
    f3 = 3'b000; addr = 2'd3; step("lb3");
`ifdef MUX_MEM_ALU_LOAD_FMT_EN
    chk("lb3_const", dout, 32'hFFFF_FF80);
`endif
    f3 = 3'b100; step("lbu3");
    f3 = 3'b000; addr = 2'd1; step("lb1");
    mem = 32'h8001_1234; addr = 2'd2;
    f3 = 3'b001; step("lh2");
`ifdef MUX_MEM_ALU_LOAD_FMT_EN
    chk("lh2_const", dout, 32'hFFFF_8001);
`endif
    f3 = 3'b101; step("lhu2");
    f3 = 3'b001; addr = 2'd0; step("lh0");
    f3 = 3'b101; addr = 2'd1; step("lhu_mis");
    f3 = 3'b010; addr = 2'd1; step("lw_mis");
`ifdef MUX_MEM_ALU_LOAD_FMT_EN
    chk("lw_mis_const", {31'h0, mout}, 32'h1);
`endif
    f3 = 3'b111; addr = 2'd2; step("rsv_mis");
    sel = 1'b0; rg = 32'hCAFE_0001; f3 = 3'b010; addr = 2'd1; step("reg_mis");
    chk("reg_mis_const", dout, 32'hCAFE_0001);
    valid = 1'b0; step("invalid");
    valid = 1'b1; sel = 1'b1; mem = 32'h5555_AAAA; addr = 2'd0; step("pre_stall");
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      mem = $urandom; rg = $urandom; sel = i[0]; valid = ~i[0];
      step("stall");
    end
    chk("stall_const", dout, 32'h5555_AAAA);
    rst_n = 1'b0; step("stall_rst");
    rst_n = 1'b1; valid = 1'b0; step("post_rst");
    chk("post_rst_const", dout, RV);
    stall = 1'b0;
    for (int i = 0; i < 300; i++) begin
      mem = $urandom; rg = $urandom; sel = $urandom_range(0, 1);
      f3 = 3'($urandom_range(0, 7)); addr = 2'($urandom_range(0, 3));
      valid = ($urandom_range(0, 3) != 0); stall = ($urandom_range(0, 4) == 0);
      rst_n = ($urandom_range(0, 30) != 0);
      step("rand");
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mux_mem_alu.md
MUX_MEM_ALU -- requirements
Module: mux_mem_alu

Interface
REQ-001 The block SHALL have exactly one clock and a synchronous, active-low reset.
REQ-002 Parameter RST_VAL, default 32'h0000_0000, SHALL set the reset value of ov_reg_Mem.
REQ-003 Port i_clk, input, 1 bit, SHALL be the single clock; all state updates on its rising edge.
REQ-004 Port i_rst_n, input, 1 bit, SHALL be the synchronous active-low reset.
REQ-005 Port iv_Mem, input, 32 bits, SHALL carry the raw load word from data memory.
REQ-006 Port iv_Reg, input, 32 bits, SHALL carry the ALU/register result.
REQ-007 Port i_selector, input, 1 bit, SHALL select the source: 1 = memory path, 0 = iv_Reg.
REQ-008 Port iv_funct3, input, 3 bits, SHALL carry the load type (RISC-V funct3).
REQ-009 Port iv_addr_lo, input, 2 bits, SHALL carry the load byte offset (address bits 1:0).
REQ-010 Port i_valid, input, 1 bit, SHALL qualify the inputs for the current cycle.
REQ-011 Port i_stall, input, 1 bit, SHALL freeze all outputs when high.
REQ-012 Port ov_reg_Mem, output, 32 bits, SHALL be the registered writeback value.
REQ-013 Port o_valid, output, 1 bit, SHALL flag ov_reg_Mem as holding a new result.
REQ-014 Port o_misaligned, output, 1 bit, SHALL flag a misaligned load for the registered result.

Function
REQ-015 Latency SHALL be exactly 1 cycle: inputs sampled at edge N appear on outputs after edge N.
REQ-016 With i_stall=0, i_valid=1: ov_reg_Mem <= selected value, o_valid <= 1, o_misaligned <= i_selector AND misaligned.
REQ-017 With i_stall=0, i_valid=0: o_valid <= 0, o_misaligned <= 0, and ov_reg_Mem SHALL hold.
REQ-018 With i_stall=1: all outputs SHALL hold regardless of the other inputs.
REQ-019 i_selector=0 SHALL pass iv_Reg unmodified; iv_funct3 and iv_addr_lo are ignored and misalignment is never flagged.
REQ-020 i_selector=1 with funct3 000 (LB) SHALL select byte iv_addr_lo and sign-extend it.
REQ-021 With funct3 100 (LBU), the selected byte SHALL be zero-extended.
REQ-022 With funct3 001 (LH), the halfword at iv_addr_lo[1] SHALL be sign-extended.
REQ-023 With funct3 101 (LHU), the halfword at iv_addr_lo[1] SHALL be zero-extended.
REQ-024 With funct3 010 (LW), iv_Mem SHALL pass whole.
REQ-025 Reserved funct3 codes 011, 110 and 111 SHALL be treated as LW.
REQ-026 Misaligned SHALL mean: LH/LHU with iv_addr_lo[0]=1, or LW/reserved with iv_addr_lo != 0; byte loads are never misaligned.
REQ-027 A misaligned memory-path result SHALL load 32'h0000_0000 into ov_reg_Mem, with o_valid=1 and o_misaligned=1.

Reset
REQ-028 On a rising i_clk edge with i_rst_n=0: ov_reg_Mem <= RST_VAL, o_valid <= 0, o_misaligned <= 0.
REQ-029 Reset SHALL dominate i_stall and i_valid, and a result held under stall SHALL be discarded.
REQ-030 Deasserting i_rst_n SHALL have no effect until the next edge; the first post-reset edge behaves per REQ-016 to REQ-018.

Configuration
REQ-031 Macro MUX_MEM_ALU_LOAD_FMT_EN defined: load formatting and misalignment detection (REQ-020 to REQ-027) SHALL be compiled in.
REQ-032 Macro MUX_MEM_ALU_LOAD_FMT_EN undefined: the memory path SHALL pass iv_Mem raw, iv_funct3 and iv_addr_lo SHALL be unused, and o_misaligned SHALL be constant 0.

Verification
REQ-033 Reset: i_rst_n=0 with i_stall=1, i_valid=1 for one edge -> ov_reg_Mem=RST_VAL, o_valid=0, o_misaligned=0.
REQ-034 Select toggle: iv_Mem=1, iv_Reg=2, funct3=010, addr=0, i_selector toggled each cycle -> ov_reg_Mem alternates 1/2, lagging i_selector by one cycle.
REQ-035 Bytes: iv_Mem=32'h80FF_7F01 -> LB addr 3 gives FFFF_FF80; LBU addr 3 gives 0000_0080; LB addr 1 gives 0000_007F.
REQ-036 Halfwords: iv_Mem=32'h8001_1234, addr 2 -> LH gives FFFF_8001; LHU gives 0000_8001; LH addr 0 gives 0000_1234.
REQ-037 Misaligned: LW addr 1 -> ov_reg_Mem=0, o_valid=1, o_misaligned=1; same with i_selector=0 -> iv_Reg, o_misaligned=0.
REQ-038 Stall: i_stall=1 for 3 cycles while inputs change -> outputs constant; reset asserted during the stall -> RST_VAL.
